fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage that sits directly upstream of the decode-side stall queue and drives its instruction input. It holds the fetch PC and addresses a synchronous instruction memory with 1-cycle read latency. It presents one instruction per cycle with its PC. Downstream stall holds the current instruction, flush redirects to a new PC with zero bubble, and a halt opcode parks the stage.

Parameters:
RESET_PC  16'h0000  first address fetched after reset
HALT_OP   4'hF      value of instr[15:12] that marks a halt instruction

Ports:
clk              in   1   single clock; all state updates on posedge
rst_n            in   1   synchronous reset, active-low
stall            in   1   downstream not accepting current output this cycle
flush            in   1   redirect request; priority over stall
flush_pc         in   16  redirect target, valid when flush=1
mem_raddr        out  16  instruction memory read address (combinational)
mem_rdata        in   16  memory data; equals mem[mem_raddr sampled at previous posedge]
out_valid        out  1   out_instruction/out_pc meaningful
out_instruction  out  16  instruction to stall queue (cur_instruction)
out_pc           out  16  PC of out_instruction
halted           out  1   stage parked on a halt instruction

Behaviour:
- State registers:
  - state ∈ {BOOT, RUN, HOLD, HALTED}
  - fetch_pc[15:0], the next address to issue
  - resp_pc[15:0], the PC of the current mem_rdata
  - hold_instr[15:0] and hold_pc[15:0]
- Reset (rst_n=0 at posedge, any state, mid-stall included): state=BOOT, fetch_pc=RESET_PC, resp_pc=0, hold regs=0.
- Reset-time outputs: out_valid=0, out_instruction=0, out_pc=0, halted=0.
- mem_raddr:
  - flush=1 → flush_pc
  - otherwise → fetch_pc
- Outputs by state:
  - RUN: valid=1, instr=mem_rdata, pc=resp_pc
  - HOLD: valid=1, instr=hold_instr, pc=hold_pc
  - BOOT/HALTED: valid=0, instr=0, pc=0
- halted=1 only in HALTED.
- All PC increments are +1 mod 2^16; 16'hFFFF wraps to 16'h0000 with no flag.
- Transitions, evaluated in priority order:
  1. flush=1 (any state): fetch_pc←flush_pc+1, resp_pc←flush_pc, state←RUN. out_valid=1 with mem[flush_pc] on the next cycle; zero bubble. The output in the flush cycle is wrong-path and is discarded downstream.
  2. BOOT: fetch_pc←fetch_pc+1, resp_pc←fetch_pc, state←RUN. stall is ignored.
  3. RUN, stall=1: hold_instr←mem_rdata, hold_pc←resp_pc, state←HOLD. fetch_pc and resp_pc are held.
  4. RUN, stall=0, instr[15:12]=HALT_OP: state←HALTED; fetch_pc held.
  5. RUN, stall=0, other instruction: fetch_pc←fetch_pc+1, resp_pc←fetch_pc.
  6. HOLD, stall=1: no change. Output remains stable for any number of stall cycles.
  7. HOLD, stall=0:
     - hold_instr[15:12]=HALT_OP → state←HALTED.
     - otherwise → fetch_pc←fetch_pc+1, resp_pc←fetch_pc, state←RUN.
     - mem_raddr was held at fetch_pc during HOLD, so mem_rdata is valid on return to RUN.
  8. HALTED: no change until flush or reset. mem_raddr continues to show fetch_pc.
- Stall with out_valid=0 (BOOT/HALTED) has no effect.
- Exactly one instruction is delivered per accepted (valid & !stall) cycle, in PC order, with no duplicates and no drops across any stall length.
- Simultaneous flush+stall: flush wins, and the held instruction is discarded.

Test Plan:
- Reset then free-run, memory mem[a]=a^16'h1000, RESET_PC=0: out_valid=0 in cycle 0. Cycles 1..5 show pc 0..4 with instructions 16'h1000..16'h1004; mem_raddr leads out_pc by 1.
- Stall for 3 cycles while out_pc=2: out stays pc=2/16'h1002 for all 3 stall cycles and the release cycle. Next cycle shows pc=3; no skip, no duplicate after release.
- Flush with flush_pc=16'h0040 during RUN, then during HOLD with stall=1: in both cases mem_raddr=16'h0040 in the flush cycle. The next cycle shows out_pc=16'h0040, out_valid=1, and state is RUN.
- Halt: mem[6]=16'hF000. Stage delivers pc 6 once, then out_valid=0 and halted=1 indefinitely. flush_pc=16'h0010 resumes with halted=0 and out_pc=16'h0010.
- Wrap: flush_pc=16'hFFFE with no stall → out_pc sequence FFFE, FFFF, 0000, 0001.
- Reset mid-HOLD (stall=1, rst_n=0 for 1 cycle): the next cycle has out_valid=0 and halted=0. The following cycle shows out_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end feeding the decode-side stall queue.
// Holds the fetch PC and drives a synchronous instruction memory that has a
// one-cycle read latency, then presents one instruction per cycle with its PC.
// A downstream stall freezes the presented instruction in a holding register.
// A flush redirects the fetch with no bubble. A halt opcode parks the stage
// until the next flush or reset.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] flush_pc,
  output logic [15:0] mem_raddr,
  input  logic [15:0] mem_rdata,
  output logic        out_valid,
  output logic [15:0] out_instruction,
  output logic [15:0] out_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] fetch_pc_r;
  logic [15:0] fetch_pc_s;
  logic [15:0] resp_pc_r;
  logic [15:0] resp_pc_s;
  logic [15:0] hold_instr_r;
  logic [15:0] hold_instr_s;
  logic [15:0] hold_pc_r;
  logic [15:0] hold_pc_s;

  // True when the opcode field of an instruction is the halt opcode.
  function automatic logic is_halt(input logic [15:0] instr);
    return (instr[15:12] == HALT_OP);
  endfunction

  // Next sequential PC. The address space wraps silently at 16'hFFFF.
  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'h0001;
  endfunction

  // A flush redirects the read address in the same cycle. This is what makes
  // the redirect bubble-free: the target's data returns on the next cycle.
  assign mem_raddr = flush ? flush_pc : fetch_pc_r;

  // Next-state logic. A flush takes priority over everything, then the state-specific moves.
  always_comb begin
    state_s      = state_r;
    fetch_pc_s   = fetch_pc_r;
    resp_pc_s    = resp_pc_r;
    hold_instr_s = hold_instr_r;
    hold_pc_s    = hold_pc_r;
    if (flush) begin
      // The flush target was issued this cycle, so the sequential fetch
      // continues from the address after it.
      fetch_pc_s = pc_inc(flush_pc);
      resp_pc_s  = flush_pc;
      state_s    = RUN;
    end else begin
      case (state_r)
        BOOT: begin
          // The first read was issued during BOOT. Nothing is on the output yet,
          // so stall is irrelevant here.
          fetch_pc_s = pc_inc(fetch_pc_r);
          resp_pc_s  = fetch_pc_r;
          state_s    = RUN;
        end
        RUN: begin
          if (stall) begin
            // Capture the presented instruction. The read of fetch_pc keeps being
            // re-issued, so the memory data is still valid when the stall ends.
            hold_instr_s = mem_rdata;
            hold_pc_s    = resp_pc_r;
            state_s      = HOLD;
          end else if (is_halt(mem_rdata)) begin
            state_s = HALTED;
          end else begin
            fetch_pc_s = pc_inc(fetch_pc_r);
            resp_pc_s  = fetch_pc_r;
            state_s    = RUN;
          end
        end
        HOLD: begin
          if (stall) begin
            state_s = HOLD;
          end else if (is_halt(hold_instr_r)) begin
            state_s = HALTED;
          end else begin
            fetch_pc_s = pc_inc(fetch_pc_r);
            resp_pc_s  = fetch_pc_r;
            state_s    = RUN;
          end
        end
        HALTED: begin
          state_s = HALTED;
        end
        default: begin
          state_s = BOOT;
        end
      endcase
    end
  end

  // State register with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= BOOT;
      fetch_pc_r   <= RESET_PC;
      resp_pc_r    <= 16'h0000;
      hold_instr_r <= 16'h0000;
      hold_pc_r    <= 16'h0000;
    end else begin
      state_r      <= state_s;
      fetch_pc_r   <= fetch_pc_s;
      resp_pc_r    <= resp_pc_s;
      hold_instr_r <= hold_instr_s;
      hold_pc_r    <= hold_pc_s;
    end
  end

  // Output selection. RUN forwards live memory data, HOLD replays the captured
  // copy, and the other states present nothing.
  always_comb begin
    out_valid       = 1'b0;
    out_instruction = 16'h0000;
    out_pc          = 16'h0000;
    halted          = 1'b0;
    case (state_r)
      RUN: begin
        out_valid       = 1'b1;
        out_instruction = mem_rdata;
        out_pc          = resp_pc_r;
      end
      HOLD: begin
        out_valid       = 1'b1;
        out_instruction = hold_instr_r;
        out_pc          = hold_pc_r;
      end
      HALTED: begin
        halted = 1'b1;
      end
      BOOT: begin
        out_valid = 1'b0;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
// The memory model is mem[a] = a ^ 16'h1000, except mem[6] = 16'hF000 (a halt).
// The model answers one cycle after the address is presented.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [15:0] flush_pc;
  logic [15:0] mem_raddr;
  logic [15:0] mem_rdata;
  logic        out_valid;
  logic [15:0] out_instruction;
  logic [15:0] out_pc;
  logic        halted;

  int tests_run;
  int tests_failed;

  fetch_stage #(.RESET_PC(16'h0000), .HALT_OP(4'hF)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .flush(flush),
    .flush_pc(flush_pc),
    .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid),
    .out_instruction(out_instruction),
    .out_pc(out_pc),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (a == 16'h0006) return 16'hF000;
    else return a ^ 16'h1000;
  endfunction

  // Synchronous memory with one-cycle read latency.
  always @(posedge clk) mem_rdata <= mem_val(mem_raddr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = 16'h0000;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", out_valid); end
    tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted got %b want 0", halted); end
    tests_run++; if (out_pc !== 16'h0000) begin tests_failed++; $display("FAIL reset_pc got %h want 0000", out_pc); end
    tests_run++; if (out_instruction !== 16'h0000) begin tests_failed++; $display("FAIL reset_instr got %h want 0000", out_instruction); end
    tests_run++; if (mem_raddr !== 16'h0000) begin tests_failed++; $display("FAIL reset_raddr got %h want 0000", mem_raddr); end
  endtask

  task automatic test_free_run();
    logic [15:0] e;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      e = 16'(i);
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL run_valid[%0d] got %b want 1", i, out_valid); end
      tests_run++; if (out_pc !== e) begin tests_failed++; $display("FAIL run_pc[%0d] got %h want %h", i, out_pc, e); end
      tests_run++; if (out_instruction !== (e ^ 16'h1000)) begin tests_failed++; $display("FAIL run_instr[%0d] got %h want %h", i, out_instruction, e ^ 16'h1000); end
      tests_run++; if (mem_raddr !== e + 16'h0001) begin tests_failed++; $display("FAIL run_raddr[%0d] got %h want %h", i, mem_raddr, e + 16'h0001); end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    tick(); tick(); tick();          // pc 2 is now on the output
    for (int i = 0; i < 4; i++) begin
      stall = (i < 3) ? 1'b1 : 1'b0; // three stall cycles, then the release cycle
      #1;
      tests_run++; if (out_pc !== 16'h0002 || out_instruction !== 16'h1002 || out_valid !== 1'b1)
        begin tests_failed++; $display("FAIL stall_hold[%0d] got %h/%h/%b want 0002/1002/1", i, out_pc, out_instruction, out_valid); end
      tests_run++; if (mem_raddr !== 16'h0003) begin tests_failed++; $display("FAIL stall_raddr[%0d] got %h want 0003", i, mem_raddr); end
      tick();
    end
    tests_run++; if (out_pc !== 16'h0003 || out_instruction !== 16'h1003) begin tests_failed++; $display("FAIL stall_after got %h/%h want 0003/1003", out_pc, out_instruction); end
    tick();
    tests_run++; if (out_pc !== 16'h0004 || out_instruction !== 16'h1004) begin tests_failed++; $display("FAIL stall_after2 got %h/%h want 0004/1004", out_pc, out_instruction); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    apply_reset();
    tick();
    e = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      stall = (i % 2 == 0) ? 1'b1 : 1'b0;
      #1;
      tests_run++; if (out_valid !== 1'b1 || out_pc !== e || out_instruction !== (e ^ 16'h1000))
        begin tests_failed++; $display("FAIL b2b[%0d] got %b/%h/%h want 1/%h/%h", i, out_valid, out_pc, out_instruction, e, e ^ 16'h1000); end
      if (stall == 1'b0) e = e + 16'h0001;
      tick();
    end
    stall = 1'b0;
  endtask

  task automatic test_flush();
    apply_reset();
    tick(); tick();
    flush = 1'b1; flush_pc = 16'h0040;
    #1;
    tests_run++; if (mem_raddr !== 16'h0040) begin tests_failed++; $display("FAIL flush_run_raddr got %h want 0040", mem_raddr); end
    tick();
    flush = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b1 || out_pc !== 16'h0040 || out_instruction !== 16'h1040)
      begin tests_failed++; $display("FAIL flush_run_out got %b/%h/%h want 1/0040/1040", out_valid, out_pc, out_instruction); end
    tick();
    tests_run++; if (out_pc !== 16'h0041) begin tests_failed++; $display("FAIL flush_run_next got %h want 0041", out_pc); end
    stall = 1'b1;
    tick(); tick();                  // in HOLD on pc 0x41
    flush = 1'b1; flush_pc = 16'h0040;
    #1;
    tests_run++; if (mem_raddr !== 16'h0040) begin tests_failed++; $display("FAIL flush_hold_raddr got %h want 0040", mem_raddr); end
    tick();
    flush = 1'b0; stall = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b1 || out_pc !== 16'h0040 || out_instruction !== 16'h1040)
      begin tests_failed++; $display("FAIL flush_hold_out got %b/%h/%h want 1/0040/1040", out_valid, out_pc, out_instruction); end
    tick();
    tests_run++; if (out_pc !== 16'h0041 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL flush_hold_next got %h/%b want 0041/1", out_pc, out_valid); end
  endtask

  task automatic test_halt();
    int seen6;
    apply_reset();
    seen6 = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (out_valid === 1'b1 && out_pc === 16'h0006) seen6++;
    end
    tests_run++; if (out_instruction !== 16'hF000 || out_pc !== 16'h0006) begin tests_failed++; $display("FAIL halt_instr got %h/%h want 0006/F000", out_pc, out_instruction); end
    for (int i = 0; i < 4; i++) begin
      stall = (i == 2) ? 1'b1 : 1'b0;
      tick();
      if (out_valid === 1'b1 && out_pc === 16'h0006) seen6++;
      tests_run++; if (out_valid !== 1'b0 || halted !== 1'b1) begin tests_failed++; $display("FAIL halt_park[%0d] got valid %b halted %b want 0/1", i, out_valid, halted); end
    end
    tests_run++; if (seen6 != 1) begin tests_failed++; $display("FAIL halt_once got %0d want 1", seen6); end
    tests_run++; if (mem_raddr !== 16'h0007) begin tests_failed++; $display("FAIL halt_raddr got %h want 0007", mem_raddr); end
    stall = 1'b0; flush = 1'b1; flush_pc = 16'h0010;
    tick();
    flush = 1'b0;
    #1;
    tests_run++; if (halted !== 1'b0 || out_valid !== 1'b1 || out_pc !== 16'h0010 || out_instruction !== 16'h1010)
      begin tests_failed++; $display("FAIL halt_resume got %b/%b/%h/%h want 0/1/0010/1010", halted, out_valid, out_pc, out_instruction); end
  endtask

  task automatic test_halt_from_hold();
    apply_reset();
    for (int i = 0; i < 7; i++) tick();   // pc 6 (halt) shown
    stall = 1'b1;
    tick(); tick();
    tests_run++; if (out_valid !== 1'b1 || out_pc !== 16'h0006 || halted !== 1'b0) begin tests_failed++; $display("FAIL halt_hold got %b/%h/%b want 1/0006/0", out_valid, out_pc, halted); end
    stall = 1'b0;
    tick();
    tests_run++; if (out_valid !== 1'b0 || halted !== 1'b1) begin tests_failed++; $display("FAIL halt_hold_park got %b/%b want 0/1", out_valid, halted); end
  endtask

  task automatic test_wrap();
    logic [15:0] e;
    apply_reset();
    tick();
    flush = 1'b1; flush_pc = 16'hFFFE;
    tick();
    flush = 1'b0;
    e = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++; if (out_valid !== 1'b1 || out_pc !== e || out_instruction !== (e ^ 16'h1000))
        begin tests_failed++; $display("FAIL wrap[%0d] got %b/%h/%h want 1/%h/%h", i, out_valid, out_pc, out_instruction, e, e ^ 16'h1000); end
      e = e + 16'h0001;
      tick();
    end
  endtask

  task automatic test_reset_in_hold();
    apply_reset();
    tick(); tick();
    stall = 1'b1;
    tick();                            // HOLD on pc 1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    tests_run++; if (out_valid !== 1'b0 || halted !== 1'b0) begin tests_failed++; $display("FAIL rst_hold got %b/%b want 0/0", out_valid, halted); end
    tick();
    tests_run++; if (out_valid !== 1'b1 || out_pc !== 16'h0000 || out_instruction !== 16'h1000)
      begin tests_failed++; $display("FAIL rst_hold_next got %b/%h/%h want 1/0000/1000", out_valid, out_pc, out_instruction); end
    stall = 1'b0;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = 16'h0000;
    tick();
    test_reset();
    test_free_run();
    test_stall();
    test_back_to_back();
    test_flush();
    test_halt();
    test_halt_from_hold();
    test_wrap();
    test_reset_in_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
